// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU-priority in RUN with UART anti-starvation, DRAIN/LOAD for exclusive UART access.
// Grant is combinational in the request cycle; read data returns one cycle later to the port that issued it.
module dmem_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_on,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_hold,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              uart_req,
    input  logic              uart_we,
    input  logic [ADDR_W-1:0] uart_addr,
    input  logic [DATA_W-1:0] uart_wdata,
    output logic              uart_gnt,
    output logic              uart_rvalid,
    output logic [DATA_W-1:0] uart_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic               cpu_pend_q, cpu_pend_d;
    logic               uart_pend_q, uart_pend_d;
    logic               cpu_grant, uart_grant;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        cpu_grant    = 1'b0;
        uart_grant   = 1'b0;
        case (state_q)
            RUN: begin
                uart_grant = uart_req & (~cpu_req | (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
                cpu_grant  = cpu_req & ~uart_grant;
                if (uart_req & ~uart_grant) begin
                    if (starve_cnt_q != CNT_W'(STARVE_LIMIT)) begin
                        starve_cnt_d = starve_cnt_q + CNT_W'(1);
                    end
                end else begin
                    starve_cnt_d = '0;
                end
                if (uart_on) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                starve_cnt_d = '0;
                state_d      = uart_on ? LOAD : RUN;
            end
            LOAD: begin
                starve_cnt_d = '0;
                if (uart_on) begin
                    uart_grant = uart_req;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d      = RUN;
                starve_cnt_d = '0;
            end
        endcase
        if (reset) begin
            cpu_grant  = 1'b0;
            uart_grant = 1'b0;
        end
        cpu_pend_d  = cpu_grant & ~cpu_we;
        uart_pend_d = uart_grant & ~uart_we;
    end

    always_comb begin
        mem_en    = cpu_grant | uart_grant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (uart_grant) begin
            mem_we    = uart_we;
            mem_addr  = uart_addr;
            mem_wdata = uart_wdata;
        end else if (cpu_grant) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
        uart_gnt    = uart_grant;
        cpu_hold    = ~reset & (state_q != RUN);
        cpu_stall   = ~reset & ((cpu_req & ~cpu_grant) | cpu_hold);
        // Pending-read flags are masked during reset so no stale pulse leaks out.
        cpu_rvalid  = ~reset & cpu_pend_q;
        uart_rvalid = ~reset & uart_pend_q;
        cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
        uart_rdata  = uart_rvalid ? mem_rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            starve_cnt_q <= '0;
            cpu_pend_q   <= 1'b0;
            uart_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_pend_q   <= cpu_pend_d;
            uart_pend_q  <= uart_pend_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small write-first, 1-cycle-latency memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        uart_on;
    logic        cpu_req, cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall, cpu_hold, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        uart_req, uart_we;
    logic [9:0]  uart_addr;
    logic [31:0] uart_wdata;
    logic        uart_gnt, uart_rvalid;
    logic [31:0] uart_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];
    logic [31:0] mem_rd_q;
    logic        ovr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr] <= mem_wdata;
                mem_rd_q      <= mem_wdata;
            end else begin
                mem_rd_q <= mem[mem_addr];
            end
        end
    end

    assign mem_rdata = ovr ? 32'hDEAD_BEEF : mem_rd_q;

    dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .uart_on(uart_on),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_hold(cpu_hold), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
        .uart_gnt(uart_gnt), .uart_rvalid(uart_rvalid), .uart_rdata(uart_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        uart_req = 1'b0; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        idle();
        ovr = 1'b0; uart_on = 1'b0; reset = 1'b1;
        mem_rd_q = '0;

        // Reset with requests active: every output stays low
        next_cycle(); cpu_req = 1'b1; uart_req = 1'b1; #1;
        chk("rst_mem_en",    32'(mem_en),    32'd0);
        chk("rst_uart_gnt",  32'(uart_gnt),  32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_cpu_hold",  32'(cpu_hold),  32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        next_cycle(); idle(); reset = 1'b0; #1;

        // 1: CPU read addr 5
        next_cycle(); cpu_req = 1'b1; cpu_addr = 10'd5; ovr = 1'b1; #1;
        chk("t1_mem_en",    32'(mem_en),    32'd1);
        chk("t1_mem_addr",  32'(mem_addr),  32'd5);
        chk("t1_mem_we",    32'(mem_we),    32'd0);
        chk("t1_stall",     32'(cpu_stall), 32'd0);
        next_cycle(); idle(); #1;
        chk("t1_rvalid",    32'(cpu_rvalid),  32'd1);
        chk("t1_rdata",     cpu_rdata,        32'hDEAD_BEEF);
        chk("t1_urvalid",   32'(uart_rvalid), 32'd0);
        chk("t1_stall2",    32'(cpu_stall),   32'd0);
        next_cycle(); ovr = 1'b0; #1;

        // 2: contention, UART forced through on the 9th cycle
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'(100 + i); cpu_wdata = 32'h100 + 32'(i);
            uart_req = 1'b1; uart_we = 1'b1; uart_addr = 10'(200 + i); uart_wdata = 32'h200 + 32'(i);
            #1;
            chk($sformatf("t2_uart_gnt_c%0d", i), 32'(uart_gnt),  32'(i == 8));
            chk($sformatf("t2_stall_c%0d", i),    32'(cpu_stall), 32'(i == 8));
            chk($sformatf("t2_addr_c%0d", i),     32'(mem_addr),  (i == 8) ? 32'd208 : 32'd100 + 32'(i));
        end

        // 3: uart_on rises during a CPU read of addr 100 (written 0x100 above)
        next_cycle(); idle(); cpu_req = 1'b1; cpu_addr = 10'd100; uart_on = 1'b1; #1;
        chk("t3_mem_en",  32'(mem_en),    32'd1);
        chk("t3_stall",   32'(cpu_stall), 32'd0);
        chk("t3_hold",    32'(cpu_hold),  32'd0);
        next_cycle(); #1;
        chk("t3_drain_hold",   32'(cpu_hold),   32'd1);
        chk("t3_drain_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t3_drain_rdata",  cpu_rdata,       32'h100);
        chk("t3_drain_mem_en", 32'(mem_en),     32'd0);
        chk("t3_drain_stall",  32'(cpu_stall),  32'd1);
        for (int j = 0; j < 3; j++) begin
            next_cycle();
            uart_req = 1'b1; uart_we = 1'b1; uart_addr = 10'(j); uart_wdata = 32'h11 * 32'(j + 1);
            #1;
            chk($sformatf("t3_gnt_%0d", j),   32'(uart_gnt),  32'd1);
            chk($sformatf("t3_we_%0d", j),    32'(mem_we),    32'd1);
            chk($sformatf("t3_addr_%0d", j),  32'(mem_addr),  32'(j));
            chk($sformatf("t3_wdat_%0d", j),  mem_wdata,      32'h11 * 32'(j + 1));
            chk($sformatf("t3_stall_%0d", j), 32'(cpu_stall), 32'd1);
        end

        // 4: uart_on falls in LOAD with uart_req still high
        next_cycle(); uart_on = 1'b0; uart_we = 1'b0; uart_addr = 10'd2; #1;
        chk("t4_uart_gnt", 32'(uart_gnt), 32'd0);
        chk("t4_mem_en",   32'(mem_en),   32'd0);
        chk("t4_hold",     32'(cpu_hold), 32'd1);
        next_cycle(); idle(); cpu_req = 1'b1; cpu_addr = 10'd1; #1;
        chk("t4_run_hold",  32'(cpu_hold),  32'd0);
        chk("t4_run_en",    32'(mem_en),    32'd1);
        chk("t4_run_stall", 32'(cpu_stall), 32'd0);
        chk("t4_run_addr",  32'(mem_addr),  32'd1);
        next_cycle(); idle(); #1;
        chk("t4_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t4_rdata",  cpu_rdata,       32'h22);

        // 5: UART read in LOAD, reset on the following cycle drops the return
        next_cycle(); uart_on = 1'b1; #1;
        next_cycle(); #1;
        chk("t5_drain_hold", 32'(cpu_hold), 32'd1);
        next_cycle(); uart_req = 1'b1; uart_addr = 10'd7; #1;
        chk("t5_gnt",    32'(uart_gnt), 32'd1);
        chk("t5_mem_en", 32'(mem_en),   32'd1);
        next_cycle(); reset = 1'b1; cpu_req = 1'b1; #1;
        chk("t5_rst_urvalid", 32'(uart_rvalid), 32'd0);
        chk("t5_rst_gnt",     32'(uart_gnt),    32'd0);
        chk("t5_rst_mem_en",  32'(mem_en),      32'd0);
        chk("t5_rst_hold",    32'(cpu_hold),    32'd0);
        chk("t5_rst_stall",   32'(cpu_stall),   32'd0);
        chk("t5_rst_urdata",  uart_rdata,       32'd0);
        next_cycle(); reset = 1'b0; uart_on = 1'b0; idle(); #1;
        chk("t5_post_urvalid", 32'(uart_rvalid), 32'd0);
        chk("t5_post_hold",    32'(cpu_hold),    32'd0);

        // 6: write then read of the same address
        next_cycle(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd3; cpu_wdata = 32'hCAFE; #1;
        chk("t6_we",     32'(mem_we),   32'd1);
        chk("t6_wdata",  mem_wdata,     32'hCAFE);
        next_cycle(); cpu_we = 1'b0; cpu_wdata = '0; #1;
        chk("t6_rd_en",      32'(mem_en),     32'd1);
        chk("t6_no_wr_rval", 32'(cpu_rvalid), 32'd0);
        next_cycle(); idle(); #1;
        chk("t6_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("t6_rdata",  cpu_rdata,       32'hCAFE);
        next_cycle(); #1;
        chk("t6_pulse_end", 32'(cpu_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
